proc_control: RTL and testbench

Sequencing controller for the 16-bit processor datapath: eight 16-bit registers R0–R7 (R7 is the PC, advanced by its `Done`/`EnableI` inputs), accumulator A, result register G, an add/sub unit and a shared bus. The block is a multi-cycle FSM. It latches a 9-bit instruction through `IRin`, then drives one-hot register write/read enables, bus-source selects and memory strobes over up to four steps. It pulses `Done` when each instruction retires.

---
 rtl/proc_pkg.sv | 29 ++
 rtl/dec3to8.sv | 16 +
 rtl/proc_control.sv | 178 +++++++++++++++++
 tb/tb_proc_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencing controller:
// instruction format, opcodes and controller states.
package proc_pkg;

    localparam int IR_W   = 9;
    localparam int N_REGS = 8;

    // R7 doubles as the program counter; writing it is a jump.
    localparam logic [2:0] PC_IDX = 3'd7;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_NOP  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic [2:0] i_w,
    input  logic       i_en,
    output logic [7:0] o_y
);

    // NOTE: assigning a default before any conditional write keeps always_comb free of inferred latches.
    always_comb begin
        o_y = '0;
        if (i_en) begin
            o_y[i_w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle sequencing FSM for the 16-bit processor datapath. The state
// register is the only storage; every control output is decoded from it and IR.
module proc_control
    import proc_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [IR_W-1:0]   IR,
    input  logic              Gnz,
    output logic [N_REGS-1:0] Rin,
    output logic [N_REGS-1:0] Rout,
    output logic              IRin,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              DINout,
    output logic              AddSub,
    output logic              ADDRin,
    output logic              DOUTin,
    output logic              W_D,
    output logic              Done,
    output logic              EnableI
);

    state_e     r_state;
    state_e     w_next_state;
    opcode_e    w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_rout_idx;
    logic       w_rin_en;
    logic       w_rout_en;
    logic       w_rout_x;
    logic       w_retire;

    assign w_op       = opcode_e'(IR[8:6]);
    assign w_x        = IR[5:3];
    assign w_y        = IR[2:0];
    assign w_rout_idx = w_rout_x ? w_x : w_y;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= T0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rin_en     = 1'b0;
        w_rout_en    = 1'b0;
        w_rout_x     = 1'b0;
        w_retire     = 1'b0;
        IRin         = 1'b0;
        Ain          = 1'b0;
        Gin          = 1'b0;
        Gout         = 1'b0;
        DINout       = 1'b0;
        AddSub       = 1'b0;
        ADDRin       = 1'b0;
        DOUTin       = 1'b0;
        W_D          = 1'b0;
        EnableI      = 1'b0;

        case (r_state)
            T0: begin
                IRin = Run;
                if (Run) begin
                    w_next_state = T1;
                end
            end
            T1: begin
                w_next_state = T2;
                case (w_op)
                    OP_MV: begin
                        w_rout_en    = 1'b1;
                        w_rin_en     = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = T0;
                    end
                    OP_MVI: EnableI = 1'b1;
                    OP_ADD, OP_SUB: begin
                        w_rout_en = 1'b1;
                        w_rout_x  = 1'b1;
                        Ain       = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        w_rout_en = 1'b1;
                        ADDRin    = 1'b1;
                    end
                    OP_MVNZ: begin
                        w_rout_en    = Gnz;
                        w_rin_en     = Gnz;
                        w_retire     = 1'b1;
                        w_next_state = T0;
                    end
                    OP_NOP: begin
                        w_retire     = 1'b1;
                        w_next_state = T0;
                    end
                endcase
            end
            T2: begin
                w_next_state = T3;
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        w_rout_en = 1'b1;
                        Gin       = 1'b1;
                        AddSub    = IR[6];
                    end
                    OP_ST: begin
                        w_rout_en    = 1'b1;
                        w_rout_x     = 1'b1;
                        DOUTin       = 1'b1;
                        W_D          = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = T0;
                    end
                    OP_MVI, OP_LD: w_next_state = T3;
                    default:       w_next_state = T0;
                endcase
            end
            T3: begin
                w_next_state = T0;
                case (w_op)
                    OP_MVI, OP_LD: begin
                        DINout   = 1'b1;
                        w_rin_en = 1'b1;
                        w_retire = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Gout     = 1'b1;
                        w_rin_en = 1'b1;
                        w_retire = 1'b1;
                    end
                    default: w_next_state = T0;
                endcase
            end
            default: w_next_state = T0;
        endcase

        // Reset silences every strobe, including the fetch strobe in T0.
        if (Reset) begin
            w_rin_en  = 1'b0;
            w_rout_en = 1'b0;
            w_retire  = 1'b0;
            IRin      = 1'b0;
            Ain       = 1'b0;
            Gin       = 1'b0;
            Gout      = 1'b0;
            DINout    = 1'b0;
            AddSub    = 1'b0;
            ADDRin    = 1'b0;
            DOUTin    = 1'b0;
            W_D       = 1'b0;
            EnableI   = 1'b0;
        end
    end

    // A write to the PC is a jump, so the retire must not also increment it.
    assign Done = w_retire && !(w_rin_en && (w_x == PC_IDX));

    dec3to8 u_dec_rin (
        .i_w  (w_x),
        .i_en (w_rin_en),
        .o_y  (Rin)
    );

    dec3to8 u_dec_rout (
        .i_w  (w_rout_idx),
        .i_en (w_rout_en),
        .o_y  (Rout)
    );

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: the stimulus pushes the expected output
// vector for each cycle, a negedge monitor pops and compares it.
module tb_proc_control;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] IR;
    logic       Gnz;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       IRin, Ain, Gin, Gout, DINout, AddSub;
    logic       ADDRin, DOUTin, W_D, Done, EnableI;

    proc_control dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Run     (Run),
        .IR      (IR),
        .Gnz     (Gnz),
        .Rin     (Rin),
        .Rout    (Rout),
        .IRin    (IRin),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .DINout  (DINout),
        .AddSub  (AddSub),
        .ADDRin  (ADDRin),
        .DOUTin  (DOUTin),
        .W_D     (W_D),
        .Done    (Done),
        .EnableI (EnableI)
    );

    localparam logic [10:0] F_IRIN = 11'h400;
    localparam logic [10:0] F_AIN  = 11'h200;
    localparam logic [10:0] F_GIN  = 11'h100;
    localparam logic [10:0] F_GOUT = 11'h080;
    localparam logic [10:0] F_DIN  = 11'h040;
    localparam logic [10:0] F_SUB  = 11'h020;
    localparam logic [10:0] F_ADDR = 11'h010;
    localparam logic [10:0] F_DOUT = 11'h008;
    localparam logic [10:0] F_WD   = 11'h004;
    localparam logic [10:0] F_DONE = 11'h002;
    localparam logic [10:0] F_ENI  = 11'h001;

    localparam logic [8:0] I_ADD   = 9'b010_000_011;
    localparam logic [8:0] I_SUB   = 9'b011_000_011;
    localparam logic [8:0] I_MV12  = 9'b000_001_010;
    localparam logic [8:0] I_MVI5  = 9'b001_101_000;
    localparam logic [8:0] I_MVNZ  = 9'b110_011_001;
    localparam logic [8:0] I_JMP   = 9'b000_111_000;
    localparam logic [8:0] I_ST    = 9'b101_100_110;
    localparam logic [8:0] I_LD    = 9'b100_010_011;
    localparam logic [8:0] I_LDPC  = 9'b100_111_000;
    localparam logic [8:0] I_NOP   = 9'b111_111_111;

    typedef struct {
        logic [26:0] v;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [26:0] w_act;

    assign w_act = {Rin, Rout, IRin, Ain, Gin, Gout, DINout, AddSub,
                    ADDRin, DOUTin, W_D, Done, EnableI};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %07h expected %07h (Rin Rout IRin Ain Gin Gout DINout AddSub ADDRin DOUTin W_D Done EnableI)",
                     name, act, req);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, w_act, e.v);
            check({e.name, "_bus"}, 27'($onehot0({Rout, Gout, DINout})), 27'd1);
        end
    end

    task automatic cyc(input logic rst, input logic run, input logic gnz, input logic [8:0] ir,
                       input logic [7:0] rin, input logic [7:0] rout, input logic [10:0] fl,
                       input string name);
        exp_t e;
        Reset = rst;
        Run   = run;
        Gnz   = gnz;
        IR    = ir;
        e.v    = {rin, rout, fl};
        e.name = name;
        q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        Gnz   = 1'b0;
        IR    = '0;
        @(posedge Clock);
        #1;

        // Reset overrides fetch, then abandons an add in T2.
        cyc(1, 1, 0, I_ADD, 8'h00, 8'h00, 11'h000,        "reset_irin0");
        cyc(0, 1, 0, I_ADD, 8'h00, 8'h00, F_IRIN,         "rst_add_t0");
        cyc(0, 0, 0, I_ADD, 8'h00, 8'h01, F_AIN,          "rst_add_t1");
        cyc(1, 0, 0, I_ADD, 8'h00, 8'h00, 11'h000,        "reset_in_t2");
        cyc(0, 0, 0, I_ADD, 8'h00, 8'h00, 11'h000,        "after_reset_t0");
        cyc(0, 1, 0, I_ADD, 8'h00, 8'h00, F_IRIN,         "after_reset_irin");

        // Full add with Run held high (ignored mid-instruction), then sub back-to-back.
        cyc(0, 1, 0, I_ADD, 8'h00, 8'h01, F_AIN,          "add_t1");
        cyc(0, 1, 0, I_ADD, 8'h00, 8'h08, F_GIN,          "add_t2");
        cyc(0, 1, 0, I_ADD, 8'h01, 8'h00, F_GOUT | F_DONE, "add_t3");
        cyc(0, 1, 0, I_SUB, 8'h00, 8'h00, F_IRIN,         "sub_t0");
        cyc(0, 0, 0, I_SUB, 8'h00, 8'h01, F_AIN,          "sub_t1");
        cyc(0, 0, 0, I_SUB, 8'h00, 8'h08, F_GIN | F_SUB,  "sub_t2");
        cyc(0, 0, 0, I_SUB, 8'h01, 8'h00, F_GOUT | F_DONE, "sub_t3");

        // mv R1,R2 then idle.
        cyc(0, 1, 0, I_MV12, 8'h00, 8'h00, F_IRIN,        "mv_t0");
        cyc(0, 0, 0, I_MV12, 8'h02, 8'h04, F_DONE,        "mv_t1");
        cyc(0, 0, 0, I_MV12, 8'h00, 8'h00, 11'h000,       "mv_idle");

        // mvi R5.
        cyc(0, 1, 0, I_MVI5, 8'h00, 8'h00, F_IRIN,        "mvi_t0");
        cyc(0, 0, 0, I_MVI5, 8'h00, 8'h00, F_ENI,         "mvi_t1");
        cyc(0, 0, 0, I_MVI5, 8'h00, 8'h00, 11'h000,       "mvi_t2");
        cyc(0, 0, 0, I_MVI5, 8'h20, 8'h00, F_DIN | F_DONE, "mvi_t3");

        // mvnz R3,R1 with G zero and nonzero.
        cyc(0, 1, 0, I_MVNZ, 8'h00, 8'h00, F_IRIN,        "mvnz0_t0");
        cyc(0, 0, 0, I_MVNZ, 8'h00, 8'h00, F_DONE,        "mvnz0_t1");
        cyc(0, 1, 1, I_MVNZ, 8'h00, 8'h00, F_IRIN,        "mvnz1_t0");
        cyc(0, 0, 1, I_MVNZ, 8'h08, 8'h02, F_DONE,        "mvnz1_t1");

        // Jump via mv R7,R0: Done suppressed.
        cyc(0, 1, 0, I_JMP, 8'h00, 8'h00, F_IRIN,         "jmp_t0");
        cyc(0, 0, 0, I_JMP, 8'h80, 8'h01, 11'h000,        "jmp_t1");

        // st R4 to [R6].
        cyc(0, 1, 0, I_ST, 8'h00, 8'h00, F_IRIN,          "st_t0");
        cyc(0, 0, 0, I_ST, 8'h00, 8'h40, F_ADDR,          "st_t1");
        cyc(0, 0, 0, I_ST, 8'h00, 8'h10, F_DOUT | F_WD | F_DONE, "st_t2");

        // ld R2 from [R3], then ld into the PC.
        cyc(0, 1, 0, I_LD, 8'h00, 8'h00, F_IRIN,          "ld_t0");
        cyc(0, 0, 0, I_LD, 8'h00, 8'h08, F_ADDR,          "ld_t1");
        cyc(0, 0, 0, I_LD, 8'h00, 8'h00, 11'h000,         "ld_t2");
        cyc(0, 0, 0, I_LD, 8'h04, 8'h00, F_DIN | F_DONE,  "ld_t3");
        cyc(0, 1, 0, I_LDPC, 8'h00, 8'h00, F_IRIN,        "ldpc_t0");
        cyc(0, 0, 0, I_LDPC, 8'h00, 8'h01, F_ADDR,        "ldpc_t1");
        cyc(0, 0, 0, I_LDPC, 8'h00, 8'h00, 11'h000,       "ldpc_t2");
        cyc(0, 0, 0, I_LDPC, 8'h80, 8'h00, F_DIN,         "ldpc_t3");

        // Reserved opcode with X=7 retires normally, no write.
        cyc(0, 1, 0, I_NOP, 8'h00, 8'h00, F_IRIN,         "nop_t0");
        cyc(0, 0, 0, I_NOP, 8'h00, 8'h00, F_DONE,         "nop_t1");
        cyc(0, 0, 0, I_NOP, 8'h00, 8'h00, 11'h000,        "final_idle");

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge Clock);
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expected vectors left, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
